// File: rtl/sha3_pad_chunker.sv
// Byte-stream to SHA-3 rate-block packer with pad10*1 and domain suffix.
// Optional SHAKE suffix selection via `SHA3_PAD_SHAKE_EN (adds the xof input).
module sha3_pad_chunker #(
   parameter int unsigned D = 512
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_data,
   input  logic               in_last,
   input  logic               in_empty,
`ifdef SHA3_PAD_SHAKE_EN
   input  logic               xof,
`endif
   output logic [1599-2*D:0]  block,
   output logic               block_valid,
   input  logic               block_ready,
   output logic               block_last
);

   localparam int unsigned R  = 1600 - 2*D;
   localparam int unsigned NB = R / 8;
   localparam int unsigned IW = 8;
   localparam logic [IW-1:0] IDX_END = IW'(NB - 1);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_OUT} state_t;

   state_t          r_state, w_state_nxt;
   logic [R-1:0]    r_block, w_block_nxt;
   logic [IW-1:0]   r_idx, w_idx_nxt;
   logic            r_last, w_last_nxt;
   logic            r_pad_pending, w_pad_pending_nxt;
   logic            r_first, w_first_nxt;
   logic            r_in_ready;
   logic            r_block_valid;
   logic            w_has_data;
   logic [7:0]      w_pad_byte;
   logic [7:0]      w_suffix;

`ifdef SHA3_PAD_SHAKE_EN
   logic [7:0]      r_suffix, w_suffix_nxt;
   assign w_suffix = r_suffix;
`else
   assign w_suffix = 8'h06;
`endif

   assign in_ready    = r_in_ready;
   assign block       = r_block;
   assign block_valid = r_block_valid;
   assign block_last  = r_last;

   // Next-state, datapath shift and padding byte selection
   always_comb begin
      w_state_nxt       = r_state;
      w_block_nxt       = r_block;
      w_idx_nxt         = r_idx;
      w_last_nxt        = r_last;
      w_pad_pending_nxt = r_pad_pending;
      w_first_nxt       = r_first;
      w_has_data        = 1'b0;
      w_pad_byte        = 8'h00;
`ifdef SHA3_PAD_SHAKE_EN
      w_suffix_nxt      = r_suffix;
`endif
      case (r_state)
         S_FILL: begin
            if (in_valid && r_in_ready) begin
               w_has_data = !(in_last && in_empty);
               if (w_has_data) begin
                  w_block_nxt = {r_block[R-9:0], in_data};
                  w_idx_nxt   = r_idx + IW'(1);
               end
               if (in_last) begin
`ifdef SHA3_PAD_SHAKE_EN
                  w_suffix_nxt = xof ? 8'h1F : 8'h06;
`endif
                  if (w_has_data && (r_idx == IDX_END)) begin
                     w_state_nxt       = S_OUT;
                     w_last_nxt        = 1'b0;
                     w_pad_pending_nxt = 1'b1;
                  end else begin
                     w_state_nxt = S_PAD;
                     w_first_nxt = 1'b1;
                  end
               end else if (r_idx == IDX_END) begin
                  w_state_nxt = S_OUT;
                  w_last_nxt  = 1'b0;
               end
            end
         end
         S_PAD: begin
            w_pad_byte  = (r_first ? w_suffix : 8'h00) | ((r_idx == IDX_END) ? 8'h80 : 8'h00);
            w_block_nxt = {r_block[R-9:0], w_pad_byte};
            w_idx_nxt   = r_idx + IW'(1);
            w_first_nxt = 1'b0;
            if (r_idx == IDX_END) begin
               w_state_nxt = S_OUT;
               w_last_nxt  = 1'b1;
            end
         end
         S_OUT: begin
            if (block_ready) begin
               w_idx_nxt  = '0;
               w_last_nxt = 1'b0;
               if (r_pad_pending) begin
                  w_pad_pending_nxt = 1'b0;
                  w_first_nxt       = 1'b1;
                  w_state_nxt       = S_PAD;
               end else begin
                  w_state_nxt = S_FILL;
               end
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   // Handshake flags are registered from the next state so neither depends on block_ready
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= S_FILL;
         r_block       <= '0;
         r_idx         <= '0;
         r_last        <= 1'b0;
         r_pad_pending <= 1'b0;
         r_first       <= 1'b0;
         r_in_ready    <= 1'b0;
         r_block_valid <= 1'b0;
`ifdef SHA3_PAD_SHAKE_EN
         r_suffix      <= 8'h06;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_block       <= w_block_nxt;
         r_idx         <= w_idx_nxt;
         r_last        <= w_last_nxt;
         r_pad_pending <= w_pad_pending_nxt;
         r_first       <= w_first_nxt;
         r_in_ready    <= (w_state_nxt == S_FILL);
         r_block_valid <= (w_state_nxt == S_OUT);
`ifdef SHA3_PAD_SHAKE_EN
         r_suffix      <= w_suffix_nxt;
`endif
      end
   end

endmodule

// File: doc/sha3_pad_chunker.md
# sha3_pad_chunker

Byte-stream front end for the `keccak` core. It packs an incoming message, one byte per handshake, into r-bit rate blocks and applies SHA-3 pad10*1 padding with the domain suffix in hardware. It presents each finished block on a valid/ready output for the sponge's absorb port. The block's packing and padding are bit-identical to the software chunking used by the NIST-vector benches, so those benches can drive raw `Msg` bytes through it.

## Interface
- `D`, 512: digest length in bits (512/384/256/224); rate `R = 1600 - 2*D` is a derived localparam; `NB = R/8` bytes per block.
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: byte-side valid.
- `in_ready` output 1: byte-side ready.
- `in_data` input 8: message byte.
- `in_last` input 1: marks the final transfer of a message.
- `in_empty` input 1: with `in_last`, the transfer carries no data byte (zero-length tail); ignored when `in_last=0`.
- `block` output R: rate block, first message byte in `block[R-1:R-8]`.
- `block_valid` output 1: block holds a complete block.
- `block_ready` input 1: downstream accepts the block.
- `block_last` output 1: qualifies `block_valid`; this is the final (padded) block of the message.

## Operation
- The datapath is a shift register: each written byte does `block <= {block[R-9:0], byte}`. Byte index `idx` runs from 0 to NB-1.
- The FSM has three states: FILL, PAD, OUT.
- FILL:
  - `in_ready=1`. A transfer occurs when `in_valid & in_ready`.
  - A non-empty transfer shifts `in_data` and increments `idx`.
  - Non-last transfer with `idx` reaching NB: go to OUT, `last_q=0`.
  - `in_last` transfer (after any data shift), `idx` < NB: go to PAD.
  - `in_last` transfer, block exactly full: go to OUT with `last_q=0` and `pad_pending=1`.
- PAD:
  - `in_ready=0`. One byte is written per cycle.
  - First pad byte: `SUFFIX` (0x06). Middle bytes: 0x00. Byte written at `idx=NB-1`: 0x80.
  - If the first pad byte lands at `idx=NB-1`, write `SUFFIX|0x80` (0x86).
  - After the 0x80 byte: go to OUT with `last_q=1`.
- OUT:
  - `block_valid=1`, `block_last=last_q`, `in_ready=0`.
  - On `block_ready`: clear `idx`.
  - If `pad_pending`: clear it and go to PAD (an all-pad block 06 00…00 80 follows). Otherwise go to FILL.
- Reset mid-operation discards any partial block.

## Timing
- Reset values:
  - `in_ready=0` during reset, 1 in the first cycle after release (FILL).
  - `block_valid=0`, `block_last=0`, `block=0`, `idx=0`, `pad_pending=0`.
- Throughput is one byte per cycle in FILL.
- PAD lasts `NB-idx` cycles, where `idx` is the value at PAD entry.
- `block_valid` rises the cycle after the byte that fills the block.
- `block` and `block_last` are stable while `block_valid & ~block_ready`.
- No combinational path from `block_ready` to `in_ready`. FILL resumes the cycle after the OUT handshake, so there is one bubble per block.
- Downstream spacing (the keccak S-cycle permutation) is enforced only through `block_ready`.

## Configuration
- `SHA3_PAD_SHAKE_EN`:
  - When defined, add input `xof` (1 bit), sampled on the `in_last` transfer. `xof=1` sets `SUFFIX=0x1F` (SHAKE), so the single-byte case becomes 0x9F. `xof=0` sets 0x06.
  - When undefined, the port is absent and `SUFFIX` is fixed at 0x06.

## Test plan
- D=512, empty message (`in_last=1`, `in_empty=1` in the first FILL cycle) -> one block 0x06, 70×0x00, 0x80; `block_last=1`; `block_valid` rises 73 cycles after the transfer.
- D=512, 71 bytes 0x00..0x46 -> one block ending in byte 0x86; `block_last=1`.
- D=512, 72 bytes -> block 1 holds the data with `block_last=0`; after its handshake, block 2 = 06 00…00 80 with `block_last=1`.
- D=256 (NB=136), 200 bytes, `block_ready` held low 10 cycles on each block -> `in_ready=0` and `block` stable while stalled; block 2 = bytes 136..199, then 0x06, zeros, 0x80.
- Assert `reset` low mid-PAD, then send an empty message -> outputs return to reset values at once; the next block equals the empty-message vector.
- `SHA3_PAD_SHAKE_EN` with D=256, `xof=1`, empty message -> block 0x1F, zeros, 0x80. Repeat with a 135-byte message -> last byte 0x9F.
